// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM state type and rotating-priority pick for mux8_rr_arbiter.
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // First set request at or after ptr, scanning upward with wrap 7->0.
    // Returns ptr when nothing is requested; callers gate on |req.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux_8_to_1_w.sv
// W-bit 8-to-1 datapath mux; slice i of din lives at din[i*W +: W].
module mux_8_to_1_w
    import mux8_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [N_REQ*W-1:0] din,
    input  logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       dout
);

    // Pure combinational select.
    always_comb begin
        dout = din[sel*W +: W];
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8-to-1 mux among eight requesters.
// Optional feature: define MUX8_ARB_HOLD_LIMIT_EN to bound each grant to
// HOLD_MAX accepted beats; otherwise a grant lasts until req[sel] drops.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int W        = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] din,
    input  logic               out_ready,
    output logic [N_REQ-1:0]   gnt,
    output logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       dout,
    output logic               out_valid,
    output logic               busy
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] win;
    logic             beat;

`ifdef MUX8_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             limit_hit;
    assign limit_hit = beat && (cnt_q == CNT_W'(HOLD_MAX - 1));
`else
    logic unused_hold;
    assign unused_hold = HOLD_MAX[0];
`endif

    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req[sel_q];
    assign beat      = out_valid & out_ready;
    assign gnt       = gnt_q;
    assign sel       = sel_q;

    // Next-state: grant from IDLE by rotating priority, release on req drop
    // (or on the last allowed beat when the hold limit is compiled in).
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        win     = rr_pick(req, ptr_q);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    sel_d      = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    ptr_d      = win + SEL_W'(1);
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
`ifdef MUX8_ARB_HOLD_LIMIT_EN
                else if (limit_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

`ifdef MUX8_ARB_HOLD_LIMIT_EN
    // Beat counter: advances on accepted beats while the grant continues,
    // cleared on every return to IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == IDLE)
            cnt_d = '0;
        else if (state_q == GRANT && beat)
            cnt_d = cnt_q + CNT_W'(1);
    end
`endif

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    mux_8_to_1_w #(.W(W)) u_mux (
        .din  (din),
        .sel  (sel_q),
        .dout (dout)
    );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_mux8_rr_arbiter;

    localparam int W  = 8;
    localparam int HM = 4;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     req;
    logic [8*W-1:0] din;
    logic           out_ready;
    logic [7:0]     gnt;
    logic [2:0]     sel;
    logic [W-1:0]   dout;
    logic           out_valid;
    logic           busy;

    int checks = 0;
    int errors = 0;

    mux8_rr_arbiter #(.W(W), .HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .dout      (dout),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_gr;
    int m_own;
    int m_ptr;
    int m_cnt;

    task automatic m_reset();
        m_gr  = 0;
        m_own = 0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // One clock edge of the arbiter, from the rules in plain arithmetic.
    task automatic m_edge();
        if (!m_gr) begin
            if (req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (req[(m_ptr + k) % 8]) begin
                        m_own = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_ptr = (m_own + 1) % 8;
                m_gr  = 1;
                m_cnt = 0;
            end
        end else if (!req[m_own]) begin
            m_gr  = 0;
            m_cnt = 0;
        end else if (HOLD_ON && out_ready) begin
            if (m_cnt == HM - 1) begin
                m_gr  = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [W-1:0] slice(input int i);
        return din[i*W +: W];
    endfunction

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = m_gr ? (8'h01 << m_own) : 8'h00;
        chk({tag, ".gnt"},       gnt,       eg);
        chk({tag, ".sel"},       sel,       m_own);
        chk({tag, ".out_valid"}, out_valid, (m_gr && req[m_own]) ? 1 : 0);
        chk({tag, ".busy"},      busy,      m_gr);
        chk({tag, ".dout"},      dout,      slice(m_own));
    endtask

    // Drive inputs, check at the falling edge, advance model at the rising edge.
    task automatic step(input logic [7:0] rq, input logic rdy, input string tag);
        req       = rq;
        out_ready = rdy;
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] rq;
        logic       rdy;
        logic [7:0] e_gnt;
        logic [2:0] e_sel;
        logic       e_vld;
        logic       e_busy;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] rq, input logic rdy, input logic [7:0] g,
                                input int s, input logic v, input logic b);
        vec_t r;
        r.rq = rq; r.rdy = rdy; r.e_gnt = g; r.e_sel = 3'(s);
        r.e_vld = v; r.e_busy = b; r.e_dout = 8'hA0 + 8'(s);
        return r;
    endfunction

    initial begin
        logic [31:0] t;
        logic [7:0]  held;

        // Order 0..7,0: idle row, one accepted beat, requester drops.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(8'hFF, 1'b1, 8'h00, (i == 0) ? 0 : i - 1, 1'b0, 1'b0));
            tbl.push_back(mk(8'hFF, 1'b1, 8'h01 << i, i, 1'b1, 1'b1));
            tbl.push_back(mk(8'hFF & ~(8'h01 << i), 1'b1, 8'h01 << i, i, 1'b0, 1'b1));
        end
        tbl.push_back(mk(8'hFF, 1'b1, 8'h00, 7, 1'b0, 1'b0));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h01, 0, 1'b1, 1'b1));

        for (int i = 0; i < 8; i++) din[i*W +: W] = 8'hA0 + 8'(i);
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b0;
        m_reset();

        // Reset state with every request asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.gnt", gnt, 8'h00);
        chk("rst.sel", sel, 3'd0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            req       = tbl[n].rq;
            out_ready = tbl[n].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d.gnt", n), gnt, tbl[n].e_gnt);
            chk($sformatf("tbl%0d.sel", n), sel, tbl[n].e_sel);
            chk($sformatf("tbl%0d.vld", n), out_valid, tbl[n].e_vld);
            chk($sformatf("tbl%0d.busy", n), busy, tbl[n].e_busy);
            chk($sformatf("tbl%0d.dout", n), dout, tbl[n].e_dout);
            @(posedge clk);
            m_edge();
            #1;
        end

        // ptr wrap: grant 6, then 7 (ptr -> 0), then 0 wins from 8'h81.
        step(8'h00, 1'b1, "wrap");
        step(8'h00, 1'b1, "wrap");
        step(8'h40, 1'b1, "wrap");
        step(8'h40, 1'b1, "wrap");
        step(8'h00, 1'b1, "wrap");
        step(8'h80, 1'b1, "wrap");
        step(8'h80, 1'b1, "wrap");
        step(8'h01, 1'b1, "wrap");
        step(8'h81, 1'b1, "wrap");
        req = 8'h81;
        @(negedge clk);
        chk("wrap.gnt0", gnt, 8'h01);
        @(posedge clk);
        m_edge();
        #1;
        step(8'h00, 1'b1, "wrap");
        step(8'h00, 1'b1, "wrap");

        // Two requesters held with consumer always ready.
        for (int i = 0; i < 14; i++) step(8'h05, 1'b1, "hold");
        step(8'h00, 1'b1, "hold");
        step(8'h00, 1'b1, "hold");

        // Stall: valid stays high and data stays put, no beat counted.
        step(8'h08, 1'b0, "stall");
        for (int i = 0; i < 3; i++) begin
            step(8'h08, 1'b0, "stall");
            chk("stall.dout", dout, 8'hA3);
            chk("stall.vld", out_valid, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(8'h08, 1'b1, "stall");
        step(8'h00, 1'b1, "stall");
        step(8'h00, 1'b1, "stall");

        // Asynchronous reset mid-grant.
        step(8'h10, 1'b1, "arst");
        step(8'h10, 1'b1, "arst");
        req = 8'h10;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.gnt", gnt, 8'h00);
        chk("arst.out_valid", out_valid, 1'b0);
        chk("arst.busy", busy, 1'b0);
        chk("arst.sel", sel, 3'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h10, 1'b1, "arst");
        step(8'h10, 1'b1, "arst");

        // Randomized traffic: requests mostly persist, occasionally toggle.
        held = 8'h00;
        for (int c = 0; c < 400; c++) begin
            t    = $urandom() & $urandom();
            held = held ^ t[7:0];
            for (int i = 0; i < 8; i++) begin
                t = $urandom();
                din[i*W +: W] = t[W-1:0];
            end
            step(held, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares one 8-to-1 datapath multiplexer among eight requesters. Grants one requester at a time, drives the mux select, and presents the selected word downstream with a valid/ready handshake. Sits between eight independent sources and a single consumer port.

## Interface
- `W`, default 8: data word width per requester.
- `HOLD_MAX`, default 4: maximum accepted beats per grant; used only when the hold-limit feature is compiled in.

- `clk`  input  1  single clock; all state on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req`  input  8  per-requester request; bit i = requester i.
- `din`  input  8*W  packed data; requester i occupies `din[i*W +: W]`.
- `out_ready`  input  1  consumer accepts the current beat.
- `gnt`  output  8  one-hot grant; all-zero when idle.
- `sel`  output  3  mux select, the encoded index of the grant.
- `dout`  output  W  `din` slice selected by `sel`.
- `out_valid`  output  1  beat present on `dout`.
- `busy`  output  1  a grant is active.

## Operation
- FSM, two states:
  - IDLE: `gnt`=0, `busy`=0.
  - GRANT: exactly one `gnt` bit set, `busy`=1.
- IDLE→GRANT when any `req` bit is high:
  - Winner is the first set bit at or after `ptr`, scanning upward with wrap 7→0.
  - Register `gnt` and `sel`; set `ptr` to winner+1 mod 8 (7 wraps to 0).
- `ptr` is 3 bits, reset 0, and changes only at grant time.
- In GRANT:
  - `out_valid = req[sel]`, combinational.
  - A beat is transferred in any cycle where `out_valid & out_ready`.
- GRANT→IDLE on either condition:
  - `req[sel]` is low (requester released).
  - Hold limit reached (see Configuration).
- Requesters must hold `din` stable while `req` and `gnt` are high and `out_ready` is low.
- Requests from non-granted sources are ignored until the FSM returns to IDLE; they are never lost while still asserted.
- `dout` is purely combinational from `din` and `sel`. It is don't-care when `out_valid`=0, but still equals the selected slice.
- Reset values:
  - `gnt`=0, `sel`=0, `busy`=0, `out_valid`=0.
  - `ptr`=0, state=IDLE, beat counter=0.
- Reset asserted mid-grant: state clears immediately (asynchronously). An in-flight beat is abandoned and no grant persists.

## Timing
- Grant latency: a request seen in IDLE at edge k produces `gnt`/`sel` valid after edge k, i.e. one cycle.
- Release: `req[sel]` low at edge k gives `gnt`=0 after edge k. The earliest next grant is after edge k+1, so there is exactly one idle bubble between grants.
- A requester that drops `req` and re-raises it next cycle competes normally. It loses to any other pending requester because `ptr` has moved past it.
- Simultaneous requests in IDLE: the strict rotating order from `ptr` decides.
- Single requester: it regains the grant after each bubble regardless of `ptr`.
- `out_ready` high while `out_valid` is low has no effect.

## Configuration
- `MUX8_ARB_HOLD_LIMIT_EN` defined:
  - A beat counter of width clog2(`HOLD_MAX`) counts accepted beats during GRANT.
  - On the beat where count equals `HOLD_MAX`-1: transition to IDLE and reset the count.
  - The counter also resets on any other return to IDLE.
  - The requester loses the grant even if `req` is still high.
- Not defined: no counter; a grant lasts until the requester drops `req`, so the grant is unbounded.

## Structure
- Package `mux8_arb_pkg`:
  - Constants `N_REQ`=8 and `SEL_W`=3.
  - FSM state enum (IDLE, GRANT).
  - Rotate-priority helper function (request vector, `ptr`) → winner index.
- Sub-module `mux_8_to_1_w`: a W-bit-wide 8-to-1 mux (`din`, `sel` → `dout`), instantiated once.

## Test plan
- Reset with `req`=8'hFF, then release reset → IDLE for 1 cycle, then `gnt`=8'h01, `sel`=0, `ptr`=1.
- `req`=8'hFF held, requester drops `req` after one beat each time (`out_ready`=1) → grant order 0,1,2,…,7,0 with one bubble between grants; `dout` tracks each requester's `din`.
- `req`=8'h80 only, with `ptr`=7 → grant 7, `ptr` wraps to 0; then `req`=8'h81 → next grant goes to 0.
- `MUX8_ARB_HOLD_LIMIT_EN`, `HOLD_MAX`=4, `req`=8'h05 held, `out_ready`=1 → grant 0 for 4 beats, bubble, grant 2 for 4 beats. With the macro undefined → grant 0 persists indefinitely.
- Granted, `out_ready`=0 for 3 cycles → `out_valid`=1 and `dout` stable throughout, no beat counted; `rst_n` pulsed low mid-grant → `gnt`=0, `out_valid`=0 immediately.
